game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//  Top-level sequencer for the flappy-bird datapath, clocked on the game tick.
//  - Owns game state: IDLE -> PLAY -> DYING -> OVER -> PLAY.
//  - Edge-detects the flap button and issues single-cycle flap/restart pulses.
//  - Gates bird/column motion via run; keeps current and best score.
//  - Replaces the ad-hoc finished/btn logic in the top level.
// PARAMETERS
//  DEATH_FRAMES     60  gameClk cycles spent in DYING; legal range 1..255
//  RESTART_HOLDOFF  30  cycles in OVER before a press restarts; legal range 1..255
//  FLASH_BIT        3   timer bit driving flash; flash toggles every 2^FLASH_BIT cycles
//  SCORE_W          10  score width
// PORTS
//  gameClk     in   1        game tick clock; the only clock
//  reset       in   1        synchronous, active-high
//  btn         in   1        flap button level, already synchronized to gameClk
//  hit_column  in   1        collision flag from collision detection
//  pass_column in   1        1-cycle pulse from column generator when a column is cleared
//  run         out  1        1 only in PLAY; datapath freezes when 0
//  game_reset  out  1        1-cycle pulse clearing bird/column/collision state at game start
//  flap        out  1        1-cycle flap pulse to bird movement
//  state       out  2        0=IDLE 1=PLAY 2=DYING 3=OVER
//  flash       out  1        display blink during DYING; 0 in all other states
//  score       out  SCORE_W  current game score
//  best_score  out  SCORE_W  highest score since reset
//  new_best    out  1        1 in OVER when the last game set a new best
// BEHAVIOUR
//  - All outputs registered; every action appears on the cycle after its cause is sampled.
//  - Reset values: state=IDLE; run, game_reset, flap, flash, new_best = 0;
//    score = 0, best_score = 0; btn_q = 0; timer = 0.
//  - Reset mid-operation returns to IDLE in one cycle, regardless of state.
//  - press = btn & ~btn_q. Holding btn gives exactly one press.
//  - IDLE:
//    - press -> PLAY, with game_reset=1, run=1, score=0, new_best=0; flap stays 0.
//    - hit_column and pass_column are ignored.
//  - PLAY:
//    - press -> flap=1 for one cycle.
//    - pass_column -> score+1, saturating at 2^SCORE_W-1.
//    - hit_column -> DYING, run=0, timer=DEATH_FRAMES-1.
//    - Simultaneous events: hit wins over press (no flap). A pass on the same cycle
//      as a hit still counts.
//  - DYING:
//    - timer decrements every cycle; flash = timer[FLASH_BIT].
//    - Presses and passes are ignored.
//    - At timer==0 -> OVER, flash=0, timer=RESTART_HOLDOFF-1; best-score update here.
//  - OVER:
//    - timer decrements to 0 and holds.
//    - A press while timer!=0 is discarded, not queued.
//    - A press at timer==0 runs the IDLE start sequence (game_reset pulse,
//      score cleared, new_best cleared).
//  - game_reset and flap are never high on the same cycle.
//  - game_reset is high exactly one cycle per game start.
// CONFIGURATION
//  BEST_SCORE_EN defined:
//    - On DYING->OVER, if score > best_score: best_score <= score, new_best <= 1.
//    - A tie leaves both unchanged.
//  BEST_SCORE_EN undefined:
//    - No best-score register is built; best_score = 0, new_best = 0 always.
// TESTING
//  1. Reset; btn held high 5 cycles in IDLE -> one game_reset pulse, state=1, run=1,
//     flap never asserted.
//  2. PLAY; 3 separated presses, 4 pass_column pulses -> exactly 3 flap pulses, score=4.
//  3. PLAY; hit_column and press on the same cycle -> state=2, run=0, no flap.
//     DYING lasts exactly 60 cycles; flash toggles every 8 cycles.
//  4. OVER; press at holdoff cycle 10 -> ignored. Press after 30 cycles -> game_reset,
//     score=0, state=1.
//  5. BEST_SCORE_EN: game ending at score 7, then a game at 5 -> best_score=7,
//     new_best 1 then 0. Without macro: best_score=0 throughout.
//  6. Assert reset during DYING and during OVER -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/game_state_ctrl.sv
// Game sequencer for the flappy-bird datapath: IDLE/PLAY/DYING/OVER, flap edge detect, scoring.
// Optional best-score tracking is built only when BEST_SCORE_EN is defined.
`timescale 1ns/1ps
module game_state_ctrl #(
   parameter int DEATH_FRAMES    = 60,
   parameter int RESTART_HOLDOFF = 30,
   parameter int FLASH_BIT       = 3,
   parameter int SCORE_W         = 10
) (
   input  logic               gameClk,
   input  logic               reset,
   input  logic               btn,
   input  logic               hit_column,
   input  logic               pass_column,
   output logic               run,
   output logic               game_reset,
   output logic               flap,
   output logic [1:0]         state,
   output logic               flash,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] best_score,
   output logic               new_best
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_DYING = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   localparam logic [7:0] DEATH_LOAD = 8'(DEATH_FRAMES - 1);
   localparam logic [7:0] HOLD_LOAD  = 8'(RESTART_HOLDOFF - 1);

   state_t             st, st_n;
   logic               btn_q;
   logic               press, start;
   logic [7:0]         timer, timer_n;
   logic               run_n, gr_n, flap_n, flash_n;
   logic [SCORE_W-1:0] score_n;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (&v) ? v : v + SCORE_W'(1);
   endfunction

   assign press = btn & ~btn_q;
   // A new game starts from IDLE, or from OVER once the holdoff has fully expired.
   assign start = press & ((st == S_IDLE) | ((st == S_OVER) & (timer == 8'd0)));

   always_comb begin
      st_n    = st;
      timer_n = timer;
      run_n   = 1'b0;
      gr_n    = 1'b0;
      flap_n  = 1'b0;
      score_n = score;
      case (st)
         S_PLAY: begin
            run_n = 1'b1;
            if (pass_column) score_n = sat_inc(score);
            if (hit_column) begin
               st_n    = S_DYING;
               run_n   = 1'b0;
               timer_n = DEATH_LOAD;
            end else if (press) begin
               flap_n = 1'b1;
            end
         end
         S_DYING: begin
            if (timer == 8'd0) begin
               st_n    = S_OVER;
               timer_n = HOLD_LOAD;
            end else begin
               timer_n = timer - 8'd1;
            end
         end
         S_OVER: begin
            if (timer != 8'd0) timer_n = timer - 8'd1;
         end
         default: ;
      endcase
      if (start) begin
         st_n    = S_PLAY;
         gr_n    = 1'b1;
         run_n   = 1'b1;
         score_n = '0;
      end
      // Flash mirrors the registered timer so it stays aligned with the countdown.
      flash_n = (st_n == S_DYING) ? timer_n[FLASH_BIT] : 1'b0;
   end

   always_ff @(posedge gameClk) begin
      if (reset) begin
         st         <= S_IDLE;
         btn_q      <= 1'b0;
         timer      <= 8'd0;
         run        <= 1'b0;
         game_reset <= 1'b0;
         flap       <= 1'b0;
         flash      <= 1'b0;
         score      <= '0;
      end else begin
         st         <= st_n;
         btn_q      <= btn;
         timer      <= timer_n;
         run        <= run_n;
         game_reset <= gr_n;
         flap       <= flap_n;
         flash      <= flash_n;
         score      <= score_n;
      end
   end

   assign state = st;

`ifdef BEST_SCORE_EN
   logic               end_game;
   logic [SCORE_W-1:0] best_n;
   logic               nb_n;

   assign end_game = (st == S_DYING) & (timer == 8'd0);

   always_comb begin
      best_n = best_score;
      nb_n   = new_best;
      if (end_game && (score > best_score)) begin
         best_n = score;
         nb_n   = 1'b1;
      end
      if (start) nb_n = 1'b0;
   end

   always_ff @(posedge gameClk) begin
      if (reset) begin
         best_score <= '0;
         new_best   <= 1'b0;
      end else begin
         best_score <= best_n;
         new_best   <= nb_n;
      end
   end
`else
   assign best_score = '0;
   assign new_best   = 1'b0;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed self-checking bench for game_state_ctrl (default parameters).
`timescale 1ns/1ps
module tb_game_state_ctrl;

   localparam int SCORE_W = 10;
`ifdef BEST_SCORE_EN
   localparam bit BE = 1'b1;
`else
   localparam bit BE = 1'b0;
`endif

   logic               gameClk = 1'b0;
   logic               reset, btn, hit_column, pass_column;
   logic               run, game_reset, flap, flash, new_best;
   logic [1:0]         state;
   logic [SCORE_W-1:0] score, best_score;

   int checks = 0;
   int errors = 0;
   int gr_cnt = 0;
   int flap_cnt = 0;
   int k;
   logic [7:0] t;

   game_state_ctrl dut (
      .gameClk     (gameClk),
      .reset       (reset),
      .btn         (btn),
      .hit_column  (hit_column),
      .pass_column (pass_column),
      .run         (run),
      .game_reset  (game_reset),
      .flap        (flap),
      .state       (state),
      .flash       (flash),
      .score       (score),
      .best_score  (best_score),
      .new_best    (new_best)
   );

   always #5 gameClk = ~gameClk;

   task automatic tick();
      @(posedge gameClk);
      #1;
      gr_cnt   += int'(game_reset);
      flap_cnt += int'(flap);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_run"}, 32'(run), 32'd0);
      check({tag, "_game_reset"}, 32'(game_reset), 32'd0);
      check({tag, "_flap"}, 32'(flap), 32'd0);
      check({tag, "_flash"}, 32'(flash), 32'd0);
      check({tag, "_score"}, 32'(score), 32'd0);
      check({tag, "_best"}, 32'(best_score), 32'd0);
      check({tag, "_new_best"}, 32'(new_best), 32'd0);
   endtask

   initial begin
      reset = 1'b1; btn = 1'b0; hit_column = 1'b0; pass_column = 1'b0;
      tick(); tick();
      check_reset("por");
      reset = 1'b0;
      // IDLE ignores hits and passes
      hit_column = 1'b1; pass_column = 1'b1;
      tick();
      hit_column = 1'b0; pass_column = 1'b0;
      check("idle_ignore_state", 32'(state), 32'd0);
      check("idle_ignore_score", 32'(score), 32'd0);

      // Test 1: btn held 5 cycles in IDLE
      gr_cnt = 0; flap_cnt = 0;
      btn = 1'b1;
      tick();
      check("t1_game_reset", 32'(game_reset), 32'd1);
      check("t1_state", 32'(state), 32'd1);
      check("t1_run", 32'(run), 32'd1);
      repeat (4) tick();
      btn = 1'b0;
      tick();
      check("t1_gr_count", 32'(gr_cnt), 32'd1);
      check("t1_flap_count", 32'(flap_cnt), 32'd0);
      check("t1_state_hold", 32'(state), 32'd1);

      // Test 2: three presses of differing length, four passes
      gr_cnt = 0; flap_cnt = 0;
      for (int p = 1; p <= 3; p++) begin
         btn = 1'b1;
         repeat (p) tick();
         btn = 1'b0;
         repeat (2) tick();
      end
      repeat (4) begin
         pass_column = 1'b1; tick();
         pass_column = 1'b0; tick();
      end
      check("t2_flap_count", 32'(flap_cnt), 32'd3);
      check("t2_score", 32'(score), 32'd4);
      check("t2_gr_count", 32'(gr_cnt), 32'd0);
      repeat (2) begin
         pass_column = 1'b1; tick();
         pass_column = 1'b0; tick();
      end
      check("t2_score6", 32'(score), 32'd6);

      // Test 3: hit + press + pass together, then DYING timing and flash
      flap_cnt = 0;
      btn = 1'b1; hit_column = 1'b1; pass_column = 1'b1;
      tick();
      btn = 1'b0; hit_column = 1'b0; pass_column = 1'b0;
      check("t3_state", 32'(state), 32'd2);
      check("t3_run", 32'(run), 32'd0);
      check("t3_flap", 32'(flap), 32'd0);
      check("t3_score", 32'(score), 32'd7);
      k = 0;
      while (state == 2'd2 && k < 100) begin
         t = 8'(59 - k);
         check("t3_flash", 32'(flash), 32'(t[3]));
         btn = (k >= 20 && k < 22);
         pass_column = (k == 10);
         k++;
         tick();
      end
      btn = 1'b0; pass_column = 1'b0;
      check("t3_dying_len", 32'(k), 32'd60);
      check("t3_over_state", 32'(state), 32'd3);
      check("t3_over_flash", 32'(flash), 32'd0);
      check("t3_over_score", 32'(score), 32'd7);
      check("t3_flap_count", 32'(flap_cnt), 32'd0);
      check("t3_best", 32'(best_score), BE ? 32'd7 : 32'd0);
      check("t3_new_best", 32'(new_best), BE ? 32'd1 : 32'd0);

      // Test 4: early press discarded, restart after holdoff
      gr_cnt = 0;
      repeat (9) tick();
      btn = 1'b1;
      tick();
      btn = 1'b0;
      check("t4_early_state", 32'(state), 32'd3);
      check("t4_early_gr", 32'(game_reset), 32'd0);
      repeat (19) tick();
      check("t4_wait_state", 32'(state), 32'd3);
      check("t4_wait_gr", 32'(gr_cnt), 32'd0);
      btn = 1'b1;
      tick();
      btn = 1'b0;
      check("t4_restart_state", 32'(state), 32'd1);
      check("t4_restart_gr", 32'(game_reset), 32'd1);
      check("t4_restart_score", 32'(score), 32'd0);
      check("t4_restart_run", 32'(run), 32'd1);
      check("t4_restart_nb", 32'(new_best), 32'd0);
      check("t4_restart_best", 32'(best_score), BE ? 32'd7 : 32'd0);
      tick();
      check("t4_gr_pulse_end", 32'(game_reset), 32'd0);

      // Test 5: second game ends at 5, best stays 7
      repeat (5) begin
         pass_column = 1'b1; tick();
         pass_column = 1'b0; tick();
      end
      hit_column = 1'b1; tick(); hit_column = 1'b0;
      k = 0;
      while (state == 2'd2 && k < 100) begin k++; tick(); end
      check("t5_state", 32'(state), 32'd3);
      check("t5_score", 32'(score), 32'd5);
      check("t5_best", 32'(best_score), BE ? 32'd7 : 32'd0);
      check("t5_new_best", 32'(new_best), 32'd0);
      repeat (30) tick();
      btn = 1'b1; tick(); btn = 1'b0;
      check("t5_restart_state", 32'(state), 32'd1);

      // Test 6: reset during DYING, then during OVER
      hit_column = 1'b1; tick(); hit_column = 1'b0;
      repeat (3) tick();
      check("t6_dying_state", 32'(state), 32'd2);
      reset = 1'b1; tick();
      check_reset("rst_dying");
      reset = 1'b0; tick();
      check("t6_idle_after", 32'(state), 32'd0);
      btn = 1'b1; tick(); btn = 1'b0;
      check("t6_play_state", 32'(state), 32'd1);
      hit_column = 1'b1; tick(); hit_column = 1'b0;
      k = 0;
      while (state == 2'd2 && k < 100) begin k++; tick(); end
      repeat (2) tick();
      check("t6_over_state", 32'(state), 32'd3);
      reset = 1'b1; tick();
      check_reset("rst_over");
      reset = 1'b0; tick();

      // Score saturation
      btn = 1'b1; tick(); btn = 1'b0;
      pass_column = 1'b1;
      repeat (1030) tick();
      pass_column = 1'b0;
      tick();
      check("sat_score", 32'(score), 32'd1023);
      check("sat_state", 32'(state), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
